// File: rtl/muldiv_unit_pkg.sv
// Shared types and helpers for the RV64M multiply/divide unit.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OP_MUL  = 3'd0,
    OP_DIV  = 3'd1,
    OP_DIVU = 3'd2,
    OP_REM  = 3'd3,
    OP_REMU = 3'd4
  } mdu_op_t;

  localparam int DIV_ITERS = 64;

  function automatic logic [63:0] sext32(input logic [63:0] x);
    return {{32{x[31]}}, x[31:0]};
  endfunction

endpackage

// File: rtl/muldiv_unit_divider_iterative.sv
// Restoring unsigned divider, one quotient bit per cycle; divide by zero
// naturally yields all-ones quotient and remainder = dividend.
module divider_iterative
  import muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic        done,
  output logic [63:0] quotient,
  output logic [63:0] remainder
);

  logic [127:0] acc;
  logic [63:0]  dvs;
  logic [6:0]   count;
  logic         running;

  // acc holds {partial remainder, remaining dividend / quotient bits}
  function automatic logic [127:0] step(input logic [127:0] cur, input logic [63:0] d);
    logic [64:0] partial;
    logic [65:0] trial;
    partial = cur[127:63];
    trial   = {1'b0, partial} - {2'b00, d};
    if (!trial[65]) step = {trial[63:0], cur[62:0], 1'b1};
    else            step = {partial[63:0], cur[62:0], 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      dvs     <= '0;
      count   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        running <= 1'b0;
        count   <= '0;
      end else if (start) begin
        // first iteration is folded into the start cycle
        acc     <= step({64'd0, dividend}, divisor);
        dvs     <= divisor;
        count   <= 7'(DIV_ITERS - 1);
        running <= 1'b1;
      end else if (running) begin
        acc   <= step(acc, dvs);
        count <= count - 7'd1;
        if (count == 7'd1) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign quotient  = acc[63:0];
  assign remainder = acc[127:64];

endmodule

// File: rtl/muldiv_unit.sv
// RV64M execute-stage mul/div controller. Optional MDU_DIV_SPECIAL_BYPASS_EN
// short-circuits divide-by-zero and signed overflow without iterating.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic        flush,
  input  mdu_op_t     op,
  input  logic        is_word,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic        mul_valid,
  output logic [63:0] mul_a,
  output logic [63:0] mul_b,
  input  logic        mul_done,
  input  logic [63:0] mul_c
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t      state;
  mdu_op_t     op_q;
  logic        word_q, div_start, byp_q;
  logic [63:0] opa, opb;
  logic        div_done;
  logic [63:0] quo, rem;

  logic        signed_in, is_rem_in;
  logic [63:0] a_ext, b_ext;
  always_comb begin
    signed_in = (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
    is_rem_in = (op == OP_REM) || (op == OP_REMU);
    a_ext = a;
    b_ext = b;
    if (is_word) begin
      a_ext = signed_in ? sext32(a) : {32'd0, a[31:0]};
      b_ext = signed_in ? sext32(b) : {32'd0, b[31:0]};
    end
  end

  logic        signed_q, neg_a, neg_b;
  logic [63:0] mag_a, mag_b, quo_fix, rem_fix, div_res;
  always_comb begin
    signed_q = (op_q == OP_DIV) || (op_q == OP_REM);
    neg_a    = signed_q & opa[63];
    neg_b    = signed_q & opb[63];
    mag_a    = neg_a ? -opa : opa;
    mag_b    = neg_b ? -opb : opb;
    quo_fix  = ((neg_a ^ neg_b) && (opb != '0)) ? -quo : quo;
    rem_fix  = neg_a ? -rem : rem;
    div_res  = ((op_q == OP_REM) || (op_q == OP_REMU)) ? rem_fix : quo_fix;
    if (word_q) div_res = sext32(div_res);
  end

  logic        special;
  logic [63:0] special_res;
`ifdef MDU_DIV_SPECIAL_BYPASS_EN
  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (op != OP_MUL) begin
      if (b_ext == '0) begin
        special     = 1'b1;
        special_res = is_rem_in ? a_ext : '1;
      end else if (signed_in && (a_ext == {1'b1, 63'd0}) && (b_ext == '1)) begin
        special     = 1'b1;
        special_res = is_rem_in ? '0 : a_ext;
      end
    end
    if (is_word) special_res = sext32(special_res);
  end
`else
  assign special     = 1'b0;
  assign special_res = {63'd0, is_rem_in & 1'b0};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= OP_MUL;
      word_q    <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      div_start <= 1'b0;
      byp_q     <= 1'b0;
      mul_valid <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      done      <= 1'b0;
      div_start <= 1'b0;
      if (flush) begin
        state     <= S_IDLE;
        mul_valid <= 1'b0;
        byp_q     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (valid) begin
            op_q   <= op;
            word_q <= is_word;
            opa    <= a_ext;
            opb    <= b_ext;
            if (op == OP_MUL) begin
              state     <= S_MUL;
              mul_valid <= 1'b1;
            end else if (special) begin
              // spend one FIN cycle before the done pulse to keep T+2 latency
              state  <= S_FIN;
              byp_q  <= 1'b1;
              result <= special_res;
            end else begin
              state     <= S_DIV;
              div_start <= 1'b1;
            end
          end
          S_MUL: if (mul_done) begin
            state     <= S_FIN;
            mul_valid <= 1'b0;
            done      <= 1'b1;
            result    <= word_q ? sext32(mul_c) : mul_c;
          end
          S_DIV: if (div_done) begin
            state  <= S_FIN;
            done   <= 1'b1;
            result <= div_res;
          end
          S_FIN: begin
            if (byp_q) begin
              byp_q <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy  = (state != S_IDLE);
  assign mul_a = opa;
  assign mul_b = opb;

  divider_iterative u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .abort     (flush),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );

endmodule
